// File: rtl/vending_machine_gen2_pkg.sv
// Shared types and helpers for the gen2 vending machine core.
package vm_gen2_pkg;

    // Two-state controller: normal vending, or serially paying out change.
    typedef enum logic {
        IDLE   = 1'b0,
        RETURN = 1'b1
    } vm_state_e;

    // Widest packed table the helpers accept, and widest single entry.
    localparam int PACK_W  = 512;
    localparam int FIELD_W = 32;

    // Pull entry idx (bits wide) out of a packed table; entries above FIELD_W bits are truncated.
    function automatic logic [FIELD_W-1:0] field_at(input logic [PACK_W-1:0] vec,
                                                    input int idx, input int bits);
        logic [FIELD_W-1:0] r;
        r = '0;
        for (int b = 0; b < FIELD_W; b++) begin
            if (b < bits && (idx * bits + b) < PACK_W) begin
                r[b] = vec[idx * bits + b];
            end
        end
        return r;
    endfunction

    function automatic logic [FIELD_W-1:0] coin_value(input logic [PACK_W-1:0] vec,
                                                      input int j, input int bits);
        return field_at(vec, j, bits);
    endfunction

    function automatic logic [FIELD_W-1:0] item_price(input logic [PACK_W-1:0] vec,
                                                      input int k, input int bits);
        return field_at(vec, k, bits);
    endfunction

endpackage

// File: rtl/vending_machine_gen2_change_picker.sv
// Greedy change selection: highest-value coin that fits the balance and is still in stock.
module vm_change_picker #(
    parameter int NUM_COINS = 3,
    parameter int BAL_BITS  = 16,
    parameter int CNT_BITS  = 8
) (
    input  logic [BAL_BITS-1:0]           i_balance,
    input  logic [NUM_COINS*CNT_BITS-1:0] i_coin_cnt,
    input  logic [NUM_COINS*BAL_BITS-1:0] i_values,
    output logic [NUM_COINS-1:0]          o_pick,
    output logic                          o_found
);

    logic [NUM_COINS-1:0] w_fit;

    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : gen_fit
        assign w_fit[gi] = (i_values[gi*BAL_BITS +: BAL_BITS] <= i_balance) &&
                           (i_coin_cnt[gi*CNT_BITS +: CNT_BITS] != '0);
    end

    // Ascending scan so the last (highest-index, highest-value) fitting coin wins.
    always_comb begin
        o_pick = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (w_fit[j]) begin
                o_pick    = '0;
                o_pick[j] = 1'b1;
            end
        end
    end

    assign o_found = |w_fit;

endmodule

// File: rtl/vending_machine_gen2.sv
// Vending machine core: balance, item stock, coin inventory, idle timeout and serial change return.
module vending_machine_gen2
    import vm_gen2_pkg::*;
#(
    parameter int                            NUM_COINS   = 3,
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            BAL_BITS    = 16,
    parameter int                            CNT_BITS    = 8,
    parameter logic [NUM_COINS*BAL_BITS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
    parameter logic [NUM_ITEMS*BAL_BITS-1:0] ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400},
    parameter int                            INIT_STOCK  = 4,
    parameter int                            TIMEOUT     = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic [NUM_ITEMS-1:0] i_select_item,
    input  logic                 i_trigger_return,
    input  logic                 i_restock,
    input  logic [NUM_ITEMS-1:0] i_restock_item,
    output logic [NUM_ITEMS-1:0] o_available_item,
    output logic [NUM_ITEMS-1:0] o_output_item,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic [NUM_COINS-1:0] o_reject_coin,
    output logic [BAL_BITS-1:0]  o_balance,
    output logic                 o_busy,
    output logic                 o_change_short
);

    localparam int                  TMR_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);
    localparam logic [BAL_BITS:0]   BAL_MAX  = {1'b0, {BAL_BITS{1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(INIT_STOCK);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    vm_state_e             r_state, w_state_next;
    logic [BAL_BITS-1:0]   r_balance, w_balance_next;
    logic [TMR_BITS-1:0]   r_timer, w_timer_next;
    logic                  r_change_short, w_short_next;
    logic [CNT_BITS-1:0]   r_stock    [NUM_ITEMS];
    logic [CNT_BITS-1:0]   r_coin_cnt [NUM_COINS];
    logic [NUM_ITEMS-1:0]  r_output_item;
    logic [NUM_COINS-1:0]  r_return_coin, w_return_next;
    logic [NUM_COINS-1:0]  r_reject_coin;

    logic [BAL_BITS-1:0]   w_coin_val [NUM_COINS];
    logic [BAL_BITS-1:0]   w_price    [NUM_ITEMS];
    logic [NUM_ITEMS-1:0]  w_avail;
    logic [NUM_ITEMS-1:0]  w_sel_onehot;
    logic                  w_sel_hit;
    logic [BAL_BITS-1:0]   w_sel_price;
    logic [BAL_BITS-1:0]   w_coin_v;
    logic                  w_coin_any, w_coin_single, w_coin_accept, w_coin_reject;
    logic [BAL_BITS:0]     w_sum;
    logic [NUM_COINS*CNT_BITS-1:0] w_coin_cnt_flat;
    logic [NUM_COINS-1:0]  w_pick;
    logic                  w_found;
    logic [BAL_BITS-1:0]   w_pick_val;

    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : gen_coin
        assign w_coin_val[gi] = BAL_BITS'(coin_value(PACK_W'(COIN_VALUES), gi, BAL_BITS));
        assign w_coin_cnt_flat[gi*CNT_BITS +: CNT_BITS] = r_coin_cnt[gi];
    end

    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : gen_item
        assign w_price[gi] = BAL_BITS'(item_price(PACK_W'(ITEM_PRICES), gi, BAL_BITS));
        assign w_avail[gi] = (r_state == IDLE) && (r_balance >= w_price[gi]) &&
                             (r_stock[gi] != '0);
    end

    vm_change_picker #(
        .NUM_COINS (NUM_COINS),
        .BAL_BITS  (BAL_BITS),
        .CNT_BITS  (CNT_BITS)
    ) u_picker (
        .i_balance  (r_balance),
        .i_coin_cnt (w_coin_cnt_flat),
        .i_values   (COIN_VALUES),
        .o_pick     (w_pick),
        .o_found    (w_found)
    );

    // Lowest-index available selected item wins; descending scan lets lower indices overwrite.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_price  = '0;
        for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
            if (i_select_item[k] && w_avail[k]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[k] = 1'b1;
                w_sel_price     = w_price[k];
            end
        end
    end

    assign w_sel_hit = |w_sel_onehot;

    // Value of the inserted coin and of the coin chosen for change.
    always_comb begin
        w_coin_v   = '0;
        w_pick_val = '0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (i_input_coin[j]) w_coin_v   = w_coin_v | w_coin_val[j];
            if (w_pick[j])       w_pick_val = w_pick_val | w_coin_val[j];
        end
    end

    // Coin acceptance sees the balance after any same-cycle purchase; one extra bit catches overflow.
    assign w_coin_any    = |i_input_coin;
    assign w_coin_single = $onehot(i_input_coin);
    assign w_sum         = {1'b0, r_balance} - {1'b0, w_sel_price} + {1'b0, w_coin_v};
    assign w_coin_accept = (r_state == IDLE) && w_coin_single && (w_sum <= BAL_MAX);
    assign w_coin_reject = w_coin_any && !w_coin_accept;

    // Next-state, balance, timer and change-pulse decisions.
    always_comb begin
        w_state_next   = r_state;
        w_balance_next = r_balance;
        w_timer_next   = r_timer;
        w_short_next   = r_change_short;
        w_return_next  = '0;
        case (r_state)
            IDLE: begin
                w_balance_next = r_balance - w_sel_price + (w_coin_accept ? w_coin_v : '0);
                if (w_coin_accept) w_short_next = 1'b0;
                if (w_coin_accept || w_sel_hit || i_trigger_return) begin
                    w_timer_next = '0;
                end else if (r_balance != '0) begin
                    w_timer_next = r_timer + TMR_BITS'(1);
                end else begin
                    w_timer_next = '0;
                end
                if ((i_trigger_return && r_balance != '0) || r_timer == TMR_LAST) begin
                    w_state_next = RETURN;
                    w_timer_next = '0;
                end
            end
            RETURN: begin
                w_timer_next = '0;
                if (r_balance == '0) begin
                    w_state_next = IDLE;
                    w_short_next = 1'b0;
                end else if (w_found) begin
                    w_return_next  = w_pick;
                    w_balance_next = r_balance - w_pick_val;
                    if (r_balance == w_pick_val) begin
                        w_state_next = IDLE;
                        w_short_next = 1'b0;
                    end
                end else begin
                    w_state_next = IDLE;
                    w_short_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Control registers and one-cycle pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_balance      <= '0;
            r_timer        <= '0;
            r_change_short <= 1'b0;
            r_output_item  <= '0;
            r_return_coin  <= '0;
            r_reject_coin  <= '0;
        end else begin
            r_state        <= w_state_next;
            r_balance      <= w_balance_next;
            r_timer        <= w_timer_next;
            r_change_short <= w_short_next;
            r_output_item  <= w_sel_onehot;
            r_return_coin  <= w_return_next;
            r_reject_coin  <= w_coin_reject ? i_input_coin : '0;
        end
    end

    // Stock and coin inventory; restock wins over a same-cycle dispense, counters never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_ITEMS; k++) r_stock[k] <= CNT_INIT;
            for (int j = 0; j < NUM_COINS; j++) r_coin_cnt[j] <= CNT_INIT;
        end else begin
            for (int k = 0; k < NUM_ITEMS; k++) begin
                if (i_restock && i_restock_item[k]) begin
                    r_stock[k] <= CNT_INIT;
                end else if (w_sel_onehot[k] && r_stock[k] != '0) begin
                    r_stock[k] <= r_stock[k] - CNT_BITS'(1);
                end
            end
            for (int j = 0; j < NUM_COINS; j++) begin
                if (w_coin_accept && i_input_coin[j] && r_coin_cnt[j] != CNT_MAX) begin
                    r_coin_cnt[j] <= r_coin_cnt[j] + CNT_BITS'(1);
                end else if (w_return_next[j] && r_coin_cnt[j] != '0) begin
                    r_coin_cnt[j] <= r_coin_cnt[j] - CNT_BITS'(1);
                end
            end
        end
    end

    assign o_available_item = w_avail;
    assign o_output_item    = r_output_item;
    assign o_return_coin    = r_return_coin;
    assign o_reject_coin    = r_reject_coin;
    assign o_balance        = r_balance;
    assign o_busy           = (r_state == RETURN);
    assign o_change_short   = r_change_short;

endmodule

// File: tb/tb_vending_machine_gen2.sv
// Directed bench for vending_machine_gen2 with a pulse scoreboard (default parameters).
module tb_vending_machine_gen2;

    logic        clk;
    logic        reset;
    logic [2:0]  i_input_coin;
    logic [3:0]  i_select_item;
    logic        i_trigger_return;
    logic        i_restock;
    logic [3:0]  i_restock_item;
    logic [3:0]  o_available_item;
    logic [3:0]  o_output_item;
    logic [2:0]  o_return_coin;
    logic [2:0]  o_reject_coin;
    logic [15:0] o_balance;
    logic        o_busy;
    logic        o_change_short;

    int errors = 0;
    int checks = 0;

    logic [3:0] q_item [$];
    logic [2:0] q_ret  [$];
    logic [2:0] q_rej  [$];

    vending_machine_gen2 dut (
        .clk              (clk),
        .reset            (reset),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_restock        (i_restock),
        .i_restock_item   (i_restock_item),
        .o_available_item (o_available_item),
        .o_output_item    (o_output_item),
        .o_return_coin    (o_return_coin),
        .o_reject_coin    (o_reject_coin),
        .o_balance        (o_balance),
        .o_busy           (o_busy),
        .o_change_short   (o_change_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns later, and match any pulses against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (o_output_item != 4'b0) begin
            $display("dispense item=%b balance=%0d", o_output_item, o_balance);
            if (q_item.size() == 0) chk("item_unexpected", 32'(o_output_item), 32'd0);
            else                    chk("item_pulse", 32'(o_output_item), 32'(q_item.pop_front()));
        end
        if (o_return_coin != 3'b0) begin
            $display("change coin=%b balance=%0d", o_return_coin, o_balance);
            if (q_ret.size() == 0) chk("ret_unexpected", 32'(o_return_coin), 32'd0);
            else                   chk("ret_pulse", 32'(o_return_coin), 32'(q_ret.pop_front()));
        end
        if (o_reject_coin != 3'b0) begin
            $display("reject coin=%b balance=%0d", o_reject_coin, o_balance);
            if (q_rej.size() == 0) chk("rej_unexpected", 32'(o_reject_coin), 32'd0);
            else                   chk("rej_pulse", 32'(o_reject_coin), 32'(q_rej.pop_front()));
        end
    endtask

    task automatic ins(input logic [2:0] c);
        i_input_coin = c;
        tick();
        i_input_coin = 3'b0;
    endtask

    task automatic sel(input logic [3:0] s);
        i_select_item = s;
        tick();
        i_select_item = 4'b0;
    endtask

    task automatic trig();
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
    endtask

    // Count cycles spent busy, bounded.
    task automatic busy_len(output int n);
        n = 0;
        while (o_busy && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        reset            = 1'b1;
        i_input_coin     = 3'b0;
        i_select_item    = 4'b0;
        i_trigger_return = 1'b0;
        i_restock        = 1'b0;
        i_restock_item   = 4'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_balance", 32'(o_balance), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_short", 32'(o_change_short), 32'd0);
        chk("reset_avail", 32'(o_available_item), 32'd0);

        // Trigger with zero balance is ignored.
        trig();
        chk("trig_zero_busy", 32'(o_busy), 32'd0);

        // 1000 then 500.
        ins(3'b100);
        ins(3'b010);
        chk("bal_1500", 32'(o_balance), 32'd1500);
        chk("avail_1500", 32'(o_available_item), 32'b0111);

        // Multi-hot insert rejected and echoed.
        q_rej.push_back(3'b101);
        ins(3'b101);
        chk("multihot_bal", 32'(o_balance), 32'd1500);

        // Two buttons: only item1 dispensed.
        q_item.push_back(4'b0010);
        sel(4'b0110);
        chk("sel_bal_1000", 32'(o_balance), 32'd1000);
        chk("avail_1000", 32'(o_available_item), 32'b0111);

        // Build 1400, return 1000 + 4x100, insert during busy gets rejected.
        for (int i = 0; i < 4; i++) ins(3'b001);
        chk("bal_1400", 32'(o_balance), 32'd1400);
        trig();
        chk("ret_busy", 32'(o_busy), 32'd1);
        chk("ret_avail_masked", 32'(o_available_item), 32'd0);
        q_ret.push_back(3'b100);
        for (int i = 0; i < 4; i++) q_ret.push_back(3'b001);
        q_rej.push_back(3'b010);
        i_input_coin = 3'b010;
        n = 0;
        while (o_busy && n < 50) begin
            n++;
            tick();
            i_input_coin = 3'b0;
        end
        chk("ret5_len", 32'(n), 32'd5);
        chk("ret5_bal", 32'(o_balance), 32'd0);

        // Four purchase rounds drain the 100 inventory and item0 stock.
        for (int r = 0; r < 4; r++) begin
            ins(3'b100);
            q_item.push_back(4'b0001);
            sel(4'b0001);
            q_ret.push_back(3'b010);
            q_ret.push_back(3'b001);
            trig();
            busy_len(n);
            chk("round_len", 32'(n), 32'd2);
        end
        chk("rounds_bal", 32'(o_balance), 32'd0);

        // Item0 out of stock is masked until restocked.
        ins(3'b100);
        chk("avail_nostock", 32'(o_available_item), 32'b0110);
        sel(4'b0001);
        chk("nostock_bal", 32'(o_balance), 32'd1000);
        i_restock      = 1'b1;
        i_restock_item = 4'b0001;
        tick();
        i_restock      = 1'b0;
        i_restock_item = 4'b0;
        chk("avail_restock", 32'(o_available_item), 32'b0111);

        // 1500 - 3x400 = 300 with no 100 coins left -> short.
        ins(3'b010);
        for (int i = 0; i < 3; i++) begin
            q_item.push_back(4'b0001);
            sel(4'b0001);
        end
        chk("bal_300", 32'(o_balance), 32'd300);
        trig();
        busy_len(n);
        chk("short_len", 32'(n), 32'd1);
        chk("short_flag", 32'(o_change_short), 32'd1);
        chk("short_bal", 32'(o_balance), 32'd300);

        // Accepted coin clears short; then idle timeout.
        ins(3'b001);
        chk("short_clr", 32'(o_change_short), 32'd0);
        chk("bal_400", 32'(o_balance), 32'd400);
        n = 0;
        while (!o_busy && n < 300) begin
            n++;
            tick();
        end
        chk("timeout_cycles", 32'(n), 32'd100);
        q_ret.push_back(3'b001);
        busy_len(n);
        chk("timeout_ret_len", 32'(n), 32'd2);
        chk("timeout_short", 32'(o_change_short), 32'd1);
        chk("timeout_bal", 32'(o_balance), 32'd300);

        // Reset in the middle of a return.
        ins(3'b100);
        ins(3'b100);
        chk("bal_2300", 32'(o_balance), 32'd2300);
        trig();
        q_ret.push_back(3'b100);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_bal", 32'(o_balance), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_short", 32'(o_change_short), 32'd0);
        ins(3'b100);
        ins(3'b100);
        chk("midrst_avail", 32'(o_available_item), 32'b1111);
        q_item.push_back(4'b0001);
        sel(4'b0001);
        q_ret.push_back(3'b100);
        q_ret.push_back(3'b010);
        q_ret.push_back(3'b001);
        trig();
        busy_len(n);
        chk("midrst_ret_len", 32'(n), 32'd3);
        chk("midrst_ret_bal", 32'(o_balance), 32'd0);

        // Balance overflow boundary.
        for (int i = 0; i < 65; i++) ins(3'b100);
        chk("bal_65000", 32'(o_balance), 32'd65000);
        q_rej.push_back(3'b100);
        ins(3'b100);
        chk("ovf_1000_bal", 32'(o_balance), 32'd65000);
        ins(3'b010);
        chk("bal_65500", 32'(o_balance), 32'd65500);
        q_rej.push_back(3'b001);
        ins(3'b001);
        chk("ovf_100_bal", 32'(o_balance), 32'd65500);
        tick();

        chk("q_item_empty", 32'(q_item.size()), 32'd0);
        chk("q_ret_empty", 32'(q_ret.size()), 32'd0);
        chk("q_rej_empty", 32'(q_rej.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
